pixel_capture: RTL and testbench
================================

Name: pixel_capture

Overview:
- Upstream write-side stage of the frame buffer. Accepts a byte-serial camera stream (vsync, href, 8-bit byte) and assembles 3-byte 24-bit pixels.
- Emits exactly one frame of FRAME_PIXELS pixels as single-cycle write strobes, driving frame_buf data_in / wr_en_in directly.
- Adds frame alignment on vsync, discards partial pixels, and reports completed and short frames.

Parameters:
- DATA_WIDTH, 24, pixel width; must equal BYTE_WIDTH*BYTES_PER_PIX.
- BYTE_WIDTH, 8, width of byte_in.
- BYTES_PER_PIX, 3, bytes assembled per pixel.
- ADDR_WIDTH, 3, log2 of frame size; matches the frame buffer.
- FRAME_PIXELS, 1 << ADDR_WIDTH, pixels per captured frame.

Ports:
- wr_clk  in  1  capture clock; all inputs synchronous to it.
- reset  in  1  synchronous, active-high.
- capture_en  in  1  arm; sampled only in IDLE.
- vsync_in  in  1  frame sync, active-high pulse between frames.
- href_in  in  1  line valid; byte_in is valid on each cycle href_in=1.
- byte_in  in  BYTE_WIDTH  pixel byte, MSB component first.
- pix_data  out  DATA_WIDTH  assembled pixel; connects to data_in.
- pix_wr_n  out  1  active-low write strobe, one cycle per pixel; connects to wr_en_in.
- pix_count  out  ADDR_WIDTH+1  pixels emitted in the current frame.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when FRAME_PIXELS pixels have been emitted.
- short_frame  out  1  one-cycle pulse when vsync rises before the frame completes.

Behaviour:
- Reset: synchronous, active-high, on wr_clk.
  - Reset values: state=IDLE, pix_data=0, pix_wr_n=1, pix_count=0, busy=0, frame_done=0, short_frame=0.
  - Also clears the byte counter, byte accumulator and vsync_d.
  - Reset mid-frame aborts at once. The partial pixel is discarded and no pulse is emitted.
- vsync edge detect: vsync_d registered each cycle. rise = vsync_in & ~vsync_d; fall = ~vsync_in & vsync_d.
- States:
  - IDLE: if capture_en=1 and rise -> SYNC; otherwise stay.
  - SYNC: wait for fall -> CAPTURE. On entering CAPTURE: pix_count=0, byte counter=0.
  - CAPTURE:
    - Each cycle with href_in=1: shift byte_in into the accumulator and increment the byte counter.
    - When the byte counter reaches BYTES_PER_PIX-1 and a byte is taken: next cycle pix_data={b0,b1,b2} (b0 in the MSBs), pix_wr_n=0 for exactly one cycle, pix_count+1. Byte counter returns to 0.
    - Latency: pixel appears 1 cycle after its last byte is sampled.
  - Exits from CAPTURE:
    - The pixel making pix_count==FRAME_PIXELS: frame_done pulses in the same cycle as that strobe -> IDLE.
    - rise while pix_count<FRAME_PIXELS: short_frame pulses -> SYNC, and the next frame is recaptured from pixel 0.
- href_in falling with byte counter !=0: partial bytes are discarded, byte counter=0, no strobe.
- Bytes after the frame completes (state IDLE) are ignored. Pixels never exceed FRAME_PIXELS per frame.
- Simultaneous last byte of pixel FRAME_PIXELS and rise: the pixel is emitted and frame_done wins. No short_frame is raised; go IDLE. That rise is not used to re-arm.
- capture_en deasserted mid-frame: the current frame completes normally. capture_en is re-checked only in IDLE.
- Strobe spacing is at least BYTES_PER_PIX cycles, compatible with frame_buf FILL advancing one address per strobe.
- pix_data holds its last value between strobes.
- pix_count holds its final value in IDLE until the next CAPTURE entry.

Decomposition:
- Shared package frame_buf_pkg:
  - ASSERT/DEASSERT strobe-polarity constants.
  - capture state encoding (IDLE, SYNC, CAPTURE), with safe-encoding attribute.
  - BYTES_PER_PIX default.
- Sub-module pixel_packer:
  - Contains the byte accumulator, byte counter and href-fall discard logic.
  - Outputs pix_valid and pix_word.
  - The top level holds the FSM, vsync edge detect, pixel counter and status pulses.

Test Plan:
- Full frame: capture_en=1, vsync pulse, then href high for 24 bytes 0x01..0x18 -> 8 strobes; first pix_data=0x010203, last=0x161718. frame_done coincides with the 8th strobe; pix_count=8; back to IDLE.
- Partial pixel: href drops after bytes 0xAA,0xBB, then 0x11,0x22,0x33 follow -> single strobe with pix_data=0x112233; no 0xAABB.. pixel emitted.
- Short frame: vsync rises after 5 pixels -> short_frame pulse; pix_count=5. Next frame yields 8 strobes from pixel 0, then frame_done.
- Simultaneous: rise on the same cycle as the 24th byte -> 8th strobe plus frame_done. short_frame stays 0; state IDLE.
- Reset mid-frame: reset=1 after 4 bytes -> next cycle pix_wr_n=1, pix_count=0, busy=0. No strobes until a new vsync with capture_en=1.
- Not armed: capture_en=0 through vsync and 24 bytes -> pix_wr_n stays 1, busy=0.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Shared definitions for the frame-buffer write path.
//   WR_ASSERT / WR_DEASSERT : levels of the active-low write strobe
//   BYTES_PER_PIX_DEFAULT   : bytes assembled per pixel
//   cap_state_t             : capture FSM states (IDLE, SYNC, CAPTURE)
package frame_buf_pkg;

  localparam logic WR_ASSERT   = 1'b0;
  localparam logic WR_DEASSERT = 1'b1;

  localparam int unsigned BYTES_PER_PIX_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pixel_packer.sv
// Byte-to-pixel assembler for the capture stage.
//   clk, reset : capture clock, synchronous active-high reset
//   enable     : high while the capture FSM is in CAPTURE
//   href       : byte_in valid this cycle
//   byte_in    : incoming byte, most significant component first
//   pix_valid  : the last byte of a pixel is being taken this cycle
//   pix_word   : the completed pixel (valid with pix_valid)
module pixel_packer
  import frame_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned BYTES_PER_PIX = BYTES_PER_PIX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  href,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_word
);

  localparam int unsigned ACC_W = DATA_WIDTH - BYTE_WIDTH;
  localparam int unsigned CNT_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_PIX - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;

  // The pixel is formed combinationally from the earlier bytes plus the
  // byte on the bus; the top registers it, giving one cycle of latency.
  assign pix_valid = enable & href & (count == LAST_BYTE);
  assign pix_word  = {acc, byte_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
    end else if (!enable || !href) begin
      // Any href gap (or leaving CAPTURE) drops a partially assembled pixel.
      count <= '0;
    end else begin
      acc   <= ACC_W'({acc, byte_in});
      count <= pix_valid ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pixel_capture.sv
// Write-side capture stage: aligns to vsync, assembles byte-serial pixels
// and emits one frame of FRAME_PIXELS single-cycle write strobes.
//   wr_clk, reset : capture clock, synchronous active-high reset
//   capture_en    : arm request, sampled only in IDLE
//   vsync_in      : frame sync pulse between frames
//   href_in       : line valid, byte_in valid while high
//   byte_in       : pixel byte, MSB component first
//   pix_data      : assembled pixel (holds between strobes)
//   pix_wr_n      : active-low one-cycle write strobe per pixel
//   pix_count     : pixels emitted in the current frame
//   busy          : FSM not in IDLE
//   frame_done    : pulse with the strobe of the final pixel
//   short_frame   : pulse when vsync rises before the frame completes
module pixel_capture
  import frame_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned BYTES_PER_PIX = BYTES_PER_PIX_DEFAULT,
  parameter int unsigned ADDR_WIDTH    = 3,
  parameter int unsigned FRAME_PIXELS  = 1 << ADDR_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  capture_en,
  input  logic                  vsync_in,
  input  logic                  href_in,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_wr_n,
  output logic [ADDR_WIDTH:0]   pix_count,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  short_frame
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  (* fsm_safe_state = "reset_state" *) cap_state_t state;
  cap_state_t state_next;

  logic                  vsync_d;
  logic                  rise;
  logic                  fall;
  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_word;
  logic                  frame_last;

  assign rise = vsync_in & ~vsync_d;
  assign fall = ~vsync_in & vsync_d;

  pixel_packer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BYTE_WIDTH    (BYTE_WIDTH),
    .BYTES_PER_PIX (BYTES_PER_PIX)
  ) u_packer (
    .clk       (wr_clk),
    .reset     (reset),
    .enable    (state == CAPTURE),
    .href      (href_in),
    .byte_in   (byte_in),
    .pix_valid (pix_valid),
    .pix_word  (pix_word)
  );

  // Completing the final pixel outranks a coincident vsync rise.
  assign frame_last = pix_valid && (pix_count == LAST_PIX);

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture_en && rise) state_next = SYNC;
      SYNC:    if (fall) state_next = CAPTURE;
      CAPTURE: begin
        if (frame_last) begin
          state_next = IDLE;
        end else if (rise) begin
          state_next = SYNC;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      vsync_d     <= 1'b0;
      pix_data    <= '0;
      pix_wr_n    <= WR_DEASSERT;
      pix_count   <= '0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      vsync_d     <= vsync_in;
      pix_wr_n    <= WR_DEASSERT;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      if (state == SYNC && fall) begin
        pix_count <= '0;
      end
      if (state == CAPTURE) begin
        if (frame_last) begin
          pix_data   <= pix_word;
          pix_wr_n   <= WR_ASSERT;
          pix_count  <= pix_count + CNT_W'(1);
          frame_done <= 1'b1;
        end else if (rise) begin
          // A pixel finishing on the same edge belongs to an abandoned frame.
          short_frame <= 1'b1;
        end else if (pix_valid) begin
          pix_data  <= pix_word;
          pix_wr_n  <= WR_ASSERT;
          pix_count <= pix_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_capture.sv
// Self-checking bench for pixel_capture: frame-level vector table,
// hand-written corner sequences, and randomized frames against a
// run-grouping reference model.
module tb_pixel_capture;

  logic        wr_clk = 1'b0;
  logic        reset;
  logic        capture_en;
  logic        vsync_in;
  logic        href_in;
  logic [7:0]  byte_in;
  logic [23:0] pix_data;
  logic        pix_wr_n;
  logic [3:0]  pix_count;
  logic        busy;
  logic        frame_done;
  logic        short_frame;

  always #5 wr_clk = ~wr_clk;

  pixel_capture #(
    .DATA_WIDTH    (24),
    .BYTE_WIDTH    (8),
    .BYTES_PER_PIX (3),
    .ADDR_WIDTH    (3)
  ) dut (
    .wr_clk      (wr_clk),
    .reset       (reset),
    .capture_en  (capture_en),
    .vsync_in    (vsync_in),
    .href_in     (href_in),
    .byte_in     (byte_in),
    .pix_data    (pix_data),
    .pix_wr_n    (pix_wr_n),
    .pix_count   (pix_count),
    .busy        (busy),
    .frame_done  (frame_done),
    .short_frame (short_frame)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: collects strobed pixels and status pulses on the falling edge.
  logic [23:0] got[$];
  int done_cnt;
  int done_pos;
  int done_alone;
  int short_cnt;

  always @(negedge wr_clk) begin
    if (!reset) begin
      if (pix_wr_n === 1'b0) got.push_back(pix_data);
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_pos = got.size();
        if (pix_wr_n !== 1'b0) done_alone++;
      end
      if (short_frame === 1'b1) short_cnt++;
    end
  end

  task automatic clear_mon();
    got.delete();
    done_cnt   = 0;
    done_pos   = 0;
    done_alone = 0;
    short_cnt  = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    href_in  = 1'b0;
    vsync_in = 1'b0;
    byte_in  = '0;
    tick();
    tick();
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    tick();
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    href_in = 1'b1;
    byte_in = b;
    tick();
  endtask

  task automatic end_run();
    href_in = 1'b0;
    tick();
  endtask

  logic [7:0] nb;

  task automatic send_run(input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(nb);
      nb = nb + 8'd1;
    end
    if (n > 0) end_run();
  endtask

  typedef struct {
    logic        en;
    int          run_a;
    int          run_b;
    int          exp_strobes;
    logic [23:0] exp_first;
    logic [23:0] exp_last;
    int          exp_done;
    logic [3:0]  exp_count;
    logic        exp_busy;
  } vec_t;

  vec_t        tv[6];
  logic [23:0] exp_q[$];
  logic [7:0]  run[$];
  logic        en;
  int          avail;
  int          extra;
  int          len;

  initial begin
    reset      = 1'b1;
    capture_en = 1'b0;
    vsync_in   = 1'b0;
    href_in    = 1'b0;
    byte_in    = '0;

    tv[0] = '{en:1'b1, run_a:24, run_b:0,  exp_strobes:8, exp_first:24'h010203,
              exp_last:24'h161718, exp_done:1, exp_count:4'd8, exp_busy:1'b0};
    tv[1] = '{en:1'b1, run_a:2,  run_b:24, exp_strobes:8, exp_first:24'h030405,
              exp_last:24'h18191A, exp_done:1, exp_count:4'd8, exp_busy:1'b0};
    tv[2] = '{en:1'b0, run_a:24, run_b:0,  exp_strobes:0, exp_first:24'h0,
              exp_last:24'h0, exp_done:0, exp_count:4'd0, exp_busy:1'b0};
    tv[3] = '{en:1'b1, run_a:4,  run_b:22, exp_strobes:8, exp_first:24'h010203,
              exp_last:24'h171819, exp_done:1, exp_count:4'd8, exp_busy:1'b0};
    tv[4] = '{en:1'b1, run_a:30, run_b:0,  exp_strobes:8, exp_first:24'h010203,
              exp_last:24'h161718, exp_done:1, exp_count:4'd8, exp_busy:1'b0};
    tv[5] = '{en:1'b1, run_a:5,  run_b:4,  exp_strobes:2, exp_first:24'h010203,
              exp_last:24'h060708, exp_done:0, exp_count:4'd2, exp_busy:1'b1};

    // Reset state.
    apply_reset();
    chk("rst_pix_data", pix_data, 24'h0);
    chk("rst_pix_wr_n", pix_wr_n, 1'b1);
    chk("rst_pix_count", pix_count, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_short_frame", short_frame, 1'b0);

    // Frame-level vector table.
    for (int t = 0; t < 6; t++) begin
      apply_reset();
      capture_en = tv[t].en;
      nb = 8'h01;
      vsync_pulse();
      send_run(tv[t].run_a);
      send_run(tv[t].run_b);
      repeat (4) tick();
      chk($sformatf("tv%0d_strobes", t), got.size(), tv[t].exp_strobes);
      chk($sformatf("tv%0d_first", t), (got.size() > 0) ? got[0] : 24'h0, tv[t].exp_first);
      chk($sformatf("tv%0d_last", t), (got.size() > 0) ? got[$] : 24'h0, tv[t].exp_last);
      chk($sformatf("tv%0d_done", t), done_cnt, tv[t].exp_done);
      chk($sformatf("tv%0d_done_with_strobe", t), done_alone, 0);
      chk($sformatf("tv%0d_pix_count", t), pix_count, tv[t].exp_count);
      chk($sformatf("tv%0d_busy", t), busy, tv[t].exp_busy);
      chk($sformatf("tv%0d_short", t), short_cnt, 0);
    end

    // Partial pixel discarded when href drops.
    apply_reset();
    capture_en = 1'b1;
    vsync_pulse();
    send_byte(8'hAA);
    send_byte(8'hBB);
    end_run();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    end_run();
    chk("partial_strobes", got.size(), 1);
    chk("partial_pixel", (got.size() > 0) ? got[0] : 24'h0, 24'h112233);
    chk("partial_count", pix_count, 4'd1);

    // Short frame, then a clean recapture from pixel 0.
    apply_reset();
    capture_en = 1'b1;
    nb = 8'h01;
    vsync_pulse();
    send_run(15);
    vsync_in = 1'b1;
    tick();
    chk("short_pulse", short_frame, 1'b1);
    chk("short_count", pix_count, 4'd5);
    chk("short_busy", busy, 1'b1);
    tick();
    chk("short_pulse_one_cycle", short_frame, 1'b0);
    vsync_in = 1'b0;
    tick();
    send_run(24);
    repeat (3) tick();
    chk("short_total_strobes", got.size(), 13);
    chk("short_refirst", (got.size() > 5) ? got[5] : 24'h0, 24'h101112);
    chk("short_done", done_cnt, 1);
    chk("short_done_pos", done_pos, 13);
    chk("short_pulses", short_cnt, 1);
    chk("short_final_count", pix_count, 4'd8);

    // vsync rise coinciding with the final byte: frame_done wins.
    apply_reset();
    capture_en = 1'b1;
    nb = 8'h01;
    vsync_pulse();
    for (int i = 0; i < 23; i++) begin
      send_byte(nb);
      nb = nb + 8'd1;
    end
    vsync_in = 1'b1;
    send_byte(8'h18);
    chk("simul_strobe", pix_wr_n, 1'b0);
    chk("simul_done", frame_done, 1'b1);
    chk("simul_short", short_frame, 1'b0);
    chk("simul_data", pix_data, 24'h161718);
    href_in = 1'b0;
    tick();
    tick();
    vsync_in = 1'b0;
    tick();
    tick();
    chk("simul_idle", busy, 1'b0);
    chk("simul_no_short", short_cnt, 0);
    chk("simul_count", pix_count, 4'd8);

    // Reset mid-frame aborts, no capture until re-armed by vsync.
    apply_reset();
    capture_en = 1'b1;
    nb = 8'h01;
    vsync_pulse();
    for (int i = 0; i < 4; i++) begin
      send_byte(nb);
      nb = nb + 8'd1;
    end
    reset = 1'b1;
    tick();
    chk("midrst_wr_n", pix_wr_n, 1'b1);
    chk("midrst_count", pix_count, 4'd0);
    chk("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    href_in = 1'b0;
    clear_mon();
    tick();
    send_run(24);
    repeat (3) tick();
    chk("midrst_no_strobes", got.size(), 0);
    chk("midrst_still_idle", busy, 1'b0);
    nb = 8'h01;
    vsync_pulse();
    send_run(24);
    repeat (3) tick();
    chk("midrst_rearm_strobes", got.size(), 8);
    chk("midrst_rearm_done", done_cnt, 1);

    // Randomized frames against a run-grouping model.
    apply_reset();
    for (int f = 0; f < 20; f++) begin
      clear_mon();
      exp_q.delete();
      en = ($urandom_range(0, 3) != 0);
      capture_en = en;
      vsync_pulse();
      avail = 0;
      extra = 0;
      while (extra == 0) begin
        if (avail >= 8) extra = 1;
        len = $urandom_range(1, 10);
        run.delete();
        for (int k = 0; k < len; k++) begin
          run.push_back(8'($urandom));
          send_byte(run[k]);
        end
        href_in = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        for (int k = 0; k + 3 <= len; k += 3) begin
          avail++;
          if (en && exp_q.size() < 8) exp_q.push_back({run[k], run[k+1], run[k+2]});
        end
      end
      repeat (3) tick();
      chk($sformatf("rnd%0d_strobes", f), got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        chk($sformatf("rnd%0d_pix%0d", f, i), (i < got.size()) ? got[i] : 24'h0, exp_q[i]);
      end
      chk($sformatf("rnd%0d_done", f), done_cnt, en ? 1 : 0);
      chk($sformatf("rnd%0d_done_pos", f), done_pos, en ? 8 : 0);
      chk($sformatf("rnd%0d_short", f), short_cnt, 0);
      chk($sformatf("rnd%0d_idle", f), busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
